// File: rtl/mac_collect_pkg.sv
// Shared types and the round/saturate helper for the MAC window collector.
// Rounding is selected at build time by MAC_COLLECT_ROUND_EN.
package mac_collect_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam int OUT_W_DEF = 16;
   localparam int SHIFT_DEF = 8;

   // Returns the saturated value sign-extended to 64 bits; the caller keeps the low out_w bits.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum,
                                                    input int shift,
                                                    input int out_w);
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v = sum;
`ifdef MAC_COLLECT_ROUND_EN
      if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
`endif
      v  = v >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (v > hi)      v = hi;
      else if (v < lo) v = lo;
      return v;
   endfunction

endpackage

// File: rtl/mac_collect_fifo.sv
// Two-entry result FIFO; a push while full is accepted only when a pop happens in the same cycle.
module mac_collect_fifo
   import mac_collect_pkg::*;
#(
   parameter int W = OUT_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty,
   output logic         o_drop
);

   logic [W-1:0] r_mem [2];
   logic         r_wr;
   logic         r_rd;
   logic [1:0]   r_count;
   logic         w_push_ok;
   logic         w_pop_ok;

   assign o_full    = (r_count == 2'd2);
   assign o_empty   = (r_count == 2'd0);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign o_drop    = i_push & o_full & ~i_pop;
   assign o_data    = r_mem[r_rd];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end
         if (w_pop_ok) r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
      end
   end

endmodule

// File: rtl/mac_window_collector.sv
// Turns the free-running MAC accumulator into one rounded, saturated result per window.
// Build option MAC_COLLECT_ROUND_EN selects round-half-up instead of truncation.
module mac_window_collector
   import mac_collect_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic [ACC_W-1:0] i_acc_in,
   input  logic [ACC_W-1:0] i_prod_in,
   input  logic [CNT_W-1:0] i_win_len,
   input  logic             i_clear,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [OUT_W-1:0] o_out_data,
   output logic             o_busy,
   output logic             o_drop_flag
);

   // state | meaning
   // IDLE  | no window open; next valid sample opens one (and may close it if len==1)
   // ACCUM | window open, counting samples until cnt reaches len

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_len, w_len_nxt;
   logic [CNT_W-1:0] w_len_eff;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [ACC_W-1:0] r_base, w_base_nxt;
   logic [ACC_W-1:0] w_base_new;
   logic [ACC_W-1:0] w_base_sel;
   logic [ACC_W-1:0] w_sum;
   logic [63:0]      w_sum_ext;
   logic [OUT_W-1:0] w_result;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic             w_full;
   logic             w_empty;
   logic             r_drop;

   assign w_len_eff  = (i_win_len == '0) ? CNT_W'(1) : i_win_len;
   assign w_cnt_inc  = r_cnt + CNT_W'(1);
   assign w_base_new = i_acc_in - i_prod_in;
   // The completing sample of a length-1 window is also its first, so it must use the fresh base.
   assign w_base_sel = (r_state == IDLE) ? w_base_new : r_base;
   assign w_sum      = i_acc_in - w_base_sel;
   assign w_sum_ext  = {{(64-ACC_W){w_sum[ACC_W-1]}}, w_sum};
   assign w_result   = OUT_W'(sat_round(w_sum_ext, SHIFT, OUT_W));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_base_nxt  = r_base;
      w_push      = 1'b0;
      if (i_clear) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  w_base_nxt = w_base_new;
                  w_len_nxt  = w_len_eff;
                  w_cnt_nxt  = CNT_W'(1);
                  if (w_len_eff == CNT_W'(1)) w_push      = 1'b1;
                  else                        w_state_nxt = ACCUM;
               end
            end
            ACCUM: begin
               if (i_in_valid) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == r_len) begin
                     w_push      = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_len   <= CNT_W'(1);
         r_base  <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_base  <= w_base_nxt;
         if (w_drop) r_drop <= 1'b1;
      end
   end

   assign w_pop       = ~w_empty & i_out_ready;
   assign o_out_valid = ~w_empty;
   assign o_busy      = (r_state == ACCUM);
   assign o_drop_flag = r_drop;

   mac_collect_fifo #(
      .W (OUT_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_result),
      .o_data  (o_out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   logic w_unused;
   assign w_unused = w_full;

endmodule

// File: tb/tb_mac_window_collector.sv
// Directed bench: two collectors (SHIFT=0 and SHIFT=8) share one stimulus stream.
module tb_mac_window_collector;

`ifdef MAC_COLLECT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] acc_in;
   logic [31:0] prod_in;
   logic [7:0]  win_len;
   logic        clear;
   logic        out_ready;
   logic        v0, v8, busy0, busy8, drop0, drop8;
   logic [15:0] d0, d8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mac_window_collector #(.ACC_W(32), .OUT_W(16), .SHIFT(0), .CNT_W(8)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_acc_in(acc_in), .i_prod_in(prod_in),
      .i_win_len(win_len), .i_clear(clear), .o_out_valid(v0), .i_out_ready(out_ready),
      .o_out_data(d0), .o_busy(busy0), .o_drop_flag(drop0));

   mac_window_collector #(.ACC_W(32), .OUT_W(16), .SHIFT(8), .CNT_W(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_acc_in(acc_in), .i_prod_in(prod_in),
      .i_win_len(win_len), .i_clear(clear), .o_out_valid(v8), .i_out_ready(out_ready),
      .o_out_data(d8), .o_busy(busy8), .o_drop_flag(drop8));

   typedef struct {
      logic [31:0] prod;
      int          exp0;
      int          exp8;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int s16(input logic [15:0] x);
      return int'($signed(x));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [31:0] acc, input logic [31:0] prod);
      in_valid = 1'b1;
      acc_in   = acc;
      prod_in  = prod;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      step();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_valid"}, int'(v0 | v8), 0);
      chk({nm, "_data"},  s16(d0 | d8), 0);
      chk({nm, "_busy"},  int'(busy0 | busy8), 0);
      chk({nm, "_drop"},  int'(drop0 | drop8), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; acc_in = '0; prod_in = '0;
      win_len = 8'd1; clear = 1'b0; out_ready = 1'b1;

      vecs[0] = '{32'h0000_0180,  384,    RND ? 2    : 1};
      vecs[1] = '{32'h07FF_FFFF,  32767,  32767};
      vecs[2] = '{32'hFFFF_FE80, -384,    RND ? -1   : -2};
      vecs[3] = '{32'd100,        100,    0};
      vecs[4] = '{32'h8000_0000, -32768, -32768};
      vecs[5] = '{32'h0000_7FFF,  32767,  RND ? 128  : 127};
      vecs[6] = '{32'h0000_8000,  32767,  128};
      vecs[7] = '{32'h0000_0080,  128,    RND ? 1    : 0};
      vecs[8] = '{32'hFFFF_7FFF, -32768,  RND ? -128 : -129};
      vecs[9] = '{32'd17,         17,     0};

      #12;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      step();

      // single-sample windows: sum equals the product regardless of the accumulator value
      for (int i = 0; i < 10; i++) begin
         win_len = (i == 9) ? 8'd0 : 8'd1;
         sample(vecs[i].prod + 32'd5000, vecs[i].prod);
         chk($sformatf("vec%0d_valid", i), int'(v0), 1);
         chk($sformatf("vec%0d_d0", i), s16(d0), vecs[i].exp0);
         chk($sformatf("vec%0d_d8", i), s16(d8), vecs[i].exp8);
      end
      idle();
      chk("drain_valid", int'(v0), 0);

      // win_len=4, products 1..4 from base 100
      win_len = 8'd4;
      sample(32'd101, 32'd1);
      sample(32'd103, 32'd2);
      sample(32'd106, 32'd3);
      chk("w4_busy", int'(busy0), 1);
      chk("w4_early_valid", int'(v0), 0);
      sample(32'd110, 32'd4);
      chk("w4_valid", int'(v0), 1);
      chk("w4_d0", s16(d0), 10);
      chk("w4_d8", s16(d8), 0);
      chk("w4_busy_done", int'(busy0), 0);
      idle();

      // accumulator wrap with a gap inside the window
      win_len = 8'd2;
      sample(32'h8000_0010, 32'h20);
      idle();
      chk("wrap_gap_busy", int'(busy0), 1);
      chk("wrap_gap_valid", int'(v0), 0);
      sample(32'h8000_0030, 32'h20);
      chk("wrap_d0", s16(d0), 64);
      chk("wrap_d8", s16(d8), 0);
      idle();

      // back-to-back windows, no bubble
      sample(32'd1003, 32'd3);
      sample(32'd1007, 32'd4);
      chk("b2b_first", s16(d0), 7);
      sample(32'd1012, 32'd5);
      chk("b2b_mid_busy", int'(busy0), 1);
      chk("b2b_mid_valid", int'(v0), 0);
      sample(32'd1018, 32'd6);
      chk("b2b_second", s16(d0), 11);
      idle();

      // full FIFO with simultaneous pop and push: nothing lost
      win_len = 8'd1; out_ready = 1'b0;
      sample(32'd507, 32'd7);
      sample(32'd508, 32'd8);
      chk("full_hold_d", s16(d0), 7);
      out_ready = 1'b1;
      sample(32'd509, 32'd9);
      chk("full_pp_d", s16(d0), 8);
      chk("full_pp_drop", int'(drop0), 0);
      idle();
      chk("full_pp_next", s16(d0), 9);
      idle();
      chk("full_pp_empty", int'(v0), 0);

      // overflow: third result dropped
      out_ready = 1'b0;
      sample(32'd611, 32'd11);
      sample(32'd622, 32'd22);
      sample(32'd633, 32'd33);
      chk("drop_valid", int'(v0), 1);
      chk("drop_head", s16(d0), 11);
      chk("drop_flag", int'(drop0), 1);
      out_ready = 1'b1;
      idle();
      chk("drop_second", s16(d0), 22);
      idle();
      chk("drop_empty", int'(v0), 0);
      chk("drop_sticky", int'(drop8), 1);

      // clear at cnt=2, clear beats in_valid, then a fresh window of 4 fives
      win_len = 8'd4;
      sample(32'd2005, 32'd5);
      sample(32'd2010, 32'd5);
      clear = 1'b1;
      sample(32'd2015, 32'd5);
      clear = 1'b0;
      chk("clr_busy", int'(busy0), 0);
      chk("clr_valid", int'(v0), 0);
      sample(32'd2020, 32'd5);
      sample(32'd2025, 32'd5);
      sample(32'd2030, 32'd5);
      chk("clr_early_valid", int'(v0), 0);
      sample(32'd2035, 32'd5);
      chk("clr_d0", s16(d0), 20);
      chk("clr_d8", s16(d8), RND ? 0 : 0);
      idle();

      // reset mid-window with FIFO full
      out_ready = 1'b0; win_len = 8'd1;
      sample(32'd701, 32'd1);
      sample(32'd702, 32'd2);
      win_len = 8'd3;
      sample(32'd703, 32'd3);
      chk("pre_rst_busy", int'(busy0), 1);
      chk("pre_rst_valid", int'(v0), 1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("rst_async");
      step();
      rst = 1'b0;
      chk_all_zero("rst_held");
      out_ready = 1'b1; win_len = 8'd1;
      sample(32'd842, 32'd42);
      chk("post_rst_valid", int'(v0), 1);
      chk("post_rst_d0", s16(d0), 42);
      chk("post_rst_drop", int'(drop0), 0);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
